// File: rtl/neuro_pkg.sv
// rtl/neuro_pkg.sv - shared constants and helpers for the spiking-neuron datapath
package neuro_pkg;

   localparam int N_CH_DEF     = 3;
   localparam int WIN_LOG2_DEF = 8;
   localparam int CNT_W_DEF    = 8;
   localparam int SAT_W        = 32;

   // Callers zero-extend into SAT_W and pass their own all-ones ceiling.
   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                                input logic             inc,
                                                input logic [SAT_W-1:0] max_val);
      if (inc && (value < max_val)) begin
         sat_inc = value + SAT_W'(1);
      end else begin
         sat_inc = value;
      end
   endfunction

endpackage

// File: rtl/spike_edge_counter.sv
// rtl/spike_edge_counter.sv - rising-edge detect plus saturating per-window counter
module spike_edge_counter
   import neuro_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             spike_in,
   input  logic             win_end,
   output logic [CNT_W-1:0] load_val
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             spike_prev_q, spike_prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             edge_det;
   logic [SAT_W-1:0] inc_full;
   logic             sat_hi_unused;

   // load_val already includes an edge landing in the closing cycle.
   always_comb begin
      spike_prev_d  = spike_in;
      edge_det      = spike_in & ~spike_prev_q;
      inc_full      = sat_inc(SAT_W'(cnt_q), edge_det, SAT_W'(CNT_MAX));
      load_val      = inc_full[CNT_W-1:0];
      sat_hi_unused = ^inc_full[SAT_W-1:CNT_W];
      cnt_d         = cnt_q;
      if (en) begin
         cnt_d = win_end ? '0 : load_val;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spike_prev_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         spike_prev_q <= spike_prev_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule

// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - windowed spike-rate decoder with valid/ready result register
module spike_rate_decoder
   import neuro_pkg::*;
#(
   parameter int N_CH     = N_CH_DEF,
   parameter int WIN_LOG2 = WIN_LOG2_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [N_CH-1:0]       spike_in,
   output logic [N_CH*CNT_W-1:0] rate_data,
   output logic                  rate_valid,
   input  logic                  rate_ready,
   output logic                  overrun,
   input  logic                  clr_overrun
);

   localparam logic [WIN_LOG2-1:0] WIN_LAST = '1;

   logic [WIN_LOG2-1:0]   win_cnt_q, win_cnt_d;
   logic [N_CH*CNT_W-1:0] rate_data_q, rate_data_d;
   logic                  rate_valid_q, rate_valid_d;
   logic                  overrun_q, overrun_d;
   logic [N_CH*CNT_W-1:0] load_bus;
   logic                  win_end;
   logic                  xfer;

   assign win_end = en && (win_cnt_q == WIN_LAST);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      spike_edge_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk      (clk),
         .rst      (rst),
         .en       (en),
         .spike_in (spike_in[g]),
         .win_end  (win_end),
         .load_val (load_bus[g*CNT_W +: CNT_W])
      );
   end

   // A window end always wins over a transfer so a fresh result is never lost.
   always_comb begin
      xfer         = rate_valid_q && rate_ready;
      win_cnt_d    = en ? (win_cnt_q + WIN_LOG2'(1)) : win_cnt_q;
      rate_data_d  = win_end ? load_bus : rate_data_q;
      rate_valid_d = rate_valid_q;
      if (win_end) begin
         rate_valid_d = 1'b1;
      end else if (xfer) begin
         rate_valid_d = 1'b0;
      end
      overrun_d = overrun_q;
      if (clr_overrun) begin
         overrun_d = 1'b0;
      end
      if (win_end && rate_valid_q && !rate_ready) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_cnt_q    <= '0;
         rate_data_q  <= '0;
         rate_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         win_cnt_q    <= win_cnt_d;
         rate_data_q  <= rate_data_d;
         rate_valid_q <= rate_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   assign rate_data  = rate_data_q;
   assign rate_valid = rate_valid_q;
   assign overrun    = overrun_q;

endmodule
